// File: rtl/sva_stim_pkg.sv
// Shared types for the SVA stimulus player: verdict codes, FSM states and the
// stored vector format.
package sva_stim_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SUCC = 2'd1,
    FAIL = 2'd2,
    LAZY = 2'd3
  } exp_code_t;

  typedef enum logic [1:0] {
    IDLE,
    PRERST,
    RUN,
    FINISH
  } player_state_t;

  typedef struct packed {
    logic      a;
    exp_code_t exp;
  } vec_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // A failing verdict outranks a success, which outranks a lazy success.
  function automatic exp_code_t observed_code(input logic succ,
                                              input logic fail,
                                              input logic lazy_succ);
    if (fail)           return FAIL;
    else if (succ)      return SUCC;
    else if (lazy_succ) return LAZY;
    else                return NONE;
  endfunction

endpackage

// File: rtl/sva_vec_mem.sv
// Vector store for the stimulus player: one {a, expected verdict} entry per
// user-clock period, synchronous write and combinational read.
module sva_vec_mem
  import sva_stim_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  vec_t              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output vec_t              rd_data
);

  vec_t mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sva_stim_player.sv
// Drives gclk/grst/a into a single-signal SVA checker from a programmed vector
// list and scores the checker's verdicts against per-vector expectations.
module sva_stim_player
  import sva_stim_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DIV    = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_a,
  input  logic [1:0]        wr_exp,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              succ,
  input  logic              fail,
  input  logic              lazy_succ,
  output logic              gclk,
  output logic              grst,
  output logic              a,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic              mismatch
);

  localparam int              PH_W    = $clog2(2 * DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0] PH_FALL = PH_W'(DIV);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  player_state_t     state;
  logic [PH_W-1:0]   phase;
  logic              prst_prd;
  logic [ADDR_W:0]   k;
  logic [ADDR_W:0]   len_q;

  logic [PH_W-1:0]   phase_nxt;
  logic              period_end;
  logic              fall_next;
  logic              gclk_nxt;
  logic [ADDR_W:0]   k_next;
  logic              last_vec;
  logic              load_next;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] rd_addr;
  vec_t              rd_data;
  vec_t              mem_wr_data;
  exp_code_t         obs;
  logic              cmp_en;
  logic              cmp_hit;

  assign mem_wr_data = '{a: wr_a, exp: exp_code_t'(wr_exp)};

  sva_vec_mem #(.DEPTH(DEPTH)) u_mem (
    .sys_clk (sys_clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (mem_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The single read port serves the next vector's 'a' at the falling-edge
  // cycle and the current vector's expectation at the sampling cycle.
  always_comb begin
    period_end  = (phase == PH_LAST);
    phase_nxt   = period_end ? '0 : phase + PH_W'(1);
    fall_next   = (phase_nxt == PH_FALL);
    gclk_nxt    = (phase_nxt < PH_FALL);
    k_next      = (state == PRERST) ? '0 : k + (ADDR_W + 1)'(1);
    last_vec    = (k == len_q - (ADDR_W + 1)'(1));
    load_next   = (state == PRERST) ? (prst_prd && len_q != '0) : (k_next < len_q);
    len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    rd_addr     = period_end ? k[ADDR_W-1:0] : k_next[ADDR_W-1:0];
    obs         = observed_code(succ, fail, lazy_succ);
    cmp_en      = (state == RUN) && period_end && (rd_data.exp != NONE);
    cmp_hit     = (obs == rd_data.exp);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      prst_prd <= 1'b0;
      k        <= '0;
      len_q    <= '0;
      gclk     <= 1'b0;
      grst     <= 1'b1;
      a        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= PRERST;
            phase    <= '0;
            prst_prd <= 1'b0;
            k        <= '0;
            len_q    <= len_clamped;
            gclk     <= 1'b1;
            grst     <= 1'b1;
            a        <= 1'b0;
            busy     <= 1'b1;
            pass_cnt <= '0;
            err_cnt  <= '0;
            mismatch <= 1'b0;
          end
        end
        PRERST: begin
          phase <= phase_nxt;
          gclk  <= gclk_nxt;
          // Release the checker half a period before the first scored edge.
          if (fall_next && load_next) begin
            grst <= 1'b0;
            a    <= rd_data.a;
          end
          if (period_end) begin
            if (!prst_prd) begin
              prst_prd <= 1'b1;
            end else if (len_q != '0) begin
              state <= RUN;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
              gclk  <= 1'b0;
            end
          end
        end
        RUN: begin
          phase <= phase_nxt;
          gclk  <= gclk_nxt;
          if (fall_next && load_next) a <= rd_data.a;
          if (cmp_en) begin
            if (cmp_hit) begin
              if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 16'd1;
            end else begin
              if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 16'd1;
              mismatch <= 1'b1;
            end
          end
          if (period_end) begin
            if (last_vec) begin
              state <= FINISH;
              done  <= 1'b1;
              gclk  <= 1'b0;
              grst  <= 1'b1;
              a     <= 1'b0;
            end else begin
              k <= k + (ADDR_W + 1)'(1);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          gclk  <= 1'b0;
          grst  <= 1'b1;
          a     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
